// File: rtl/reset_request_responder.sv
// Target end of a 4-phase reset-request handshake.
// Drives a local reset, drains downstream, releases, then acknowledges.
module reset_request_responder #(
  parameter int RSTDELAY    = 2,
  parameter int HOLDOFF     = 1,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNTW        = 8,
  parameter int INIT_ASSERT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            BUSY,
  output logic            OUT_RST,
  output logic            ACK,
  output logic            TIMEOUT,
  output logic [CNTW-1:0] RST_COUNT
);

  localparam int HOLD = (HOLDOFF < 1) ? 1 : HOLDOFF;
  localparam int CMAX = (RSTDELAY > HOLD) ? RSTDELAY : HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = (TIMEOUT_CYC < 1) ? 1
                        : $clog2(TIMEOUT_CYC + 1);
  localparam bit INIT = (INIT_ASSERT != 0);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  localparam logic [CW-1:0] RD_LAST = CW'(RSTDELAY - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLD - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_DRAIN   = 3'd2,
    S_RELEASE = 3'd3,
    S_ACKW    = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [TW-1:0]   tmo_q;
  logic [TW-1:0]   tmo_d;
  logic            init_q;
  logic            init_d;
  logic            timeout_q;
  logic            timeout_d;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            out_rst_q;
  logic            ack_q;

  logic            rd_done;
  logic            ho_done;
  logic            tmo_hit;

  assign rd_done = (cnt_q == RD_LAST);
  assign ho_done = (cnt_q == HO_LAST);
  assign tmo_hit = TO_EN && (tmo_q == TO_LAST);

  // State and output registers; RST overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT ? S_ASSERT : S_IDLE;
      out_rst_q <= INIT;
      init_q    <= INIT;
      cnt_q     <= '0;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_rst_q <= (state_d == S_ASSERT) ||
                   (state_d == S_DRAIN);
      init_q    <= init_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      ack_q     <= (state_d == S_ACKW);
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (rd_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        unique case (1'b1)
          !BUSY:   state_d = S_RELEASE;
          tmo_hit: state_d = S_RELEASE;
          default: state_d = S_DRAIN;
        endcase
      end
      S_RELEASE: begin
        if (ho_done)
          state_d = init_q ? S_IDLE : S_ACKW;
      end
      S_ACKW: begin
        if (!REQ) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, flags and the acknowledged-sequence count.
  always_comb begin
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    init_d    = init_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_ASSERT: begin
        if (rd_done) begin
          cnt_d = '0;
          tmo_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        cnt_d = '0;
        if (BUSY) begin
          if (tmo_q != '1)
            tmo_d = tmo_q + TW'(1);
          if (tmo_hit)
            timeout_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (ho_done) begin
          cnt_d = '0;
          if (init_q)
            init_d = 1'b0;
          else if (count_q != '1)
            count_d = count_q + CNTW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACKW: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign OUT_RST   = out_rst_q;
  assign ACK       = ack_q;
  assign TIMEOUT   = timeout_q;
  assign RST_COUNT = count_q;

endmodule

// File: tb/tb_reset_request_responder.sv
// Directed bench for reset_request_responder.
// u0: init sequence, CNTW=8; u1: no init, CNTW=2.
module tb_reset_request_responder;

  logic       CLK = 1'b0;
  logic       rst0, req0, busy0;
  logic       rst1, req1, busy1;
  logic       out_rst0, ack0, tmo0;
  logic       out_rst1, ack1, tmo1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int checks = 0;
  int failures = 0;
  bit ackseen;

  always #5 CLK = ~CLK;

  reset_request_responder #(
    .RSTDELAY(2), .HOLDOFF(1), .TIMEOUT_CYC(8),
    .CNTW(8), .INIT_ASSERT(1)
  ) u0 (
    .CLK(CLK), .RST(rst0), .REQ(req0), .BUSY(busy0),
    .OUT_RST(out_rst0), .ACK(ack0), .TIMEOUT(tmo0),
    .RST_COUNT(cnt0)
  );

  reset_request_responder #(
    .RSTDELAY(2), .HOLDOFF(1), .TIMEOUT_CYC(8),
    .CNTW(2), .INIT_ASSERT(0)
  ) u1 (
    .CLK(CLK), .RST(rst1), .REQ(req1), .BUSY(busy1),
    .OUT_RST(out_rst1), .ACK(ack1), .TIMEOUT(tmo1),
    .RST_COUNT(cnt1)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Count cycles OUT_RST of u0 stays high; drop BUSY at n==drop_at.
  task automatic meas_high(input int drop_at, output int n);
    n = 0;
    while (out_rst0 && n < 100) begin
      n++;
      if (n == drop_at) busy0 = 1'b0;
      if (ack0) ackseen = 1'b1;
      step();
    end
  endtask

  task automatic hs1(input int exp_cnt, input string tag);
    int w;
    req1 = 1'b1;
    w = 0;
    while (!ack1 && w < 60) begin
      step();
      w++;
    end
    chk({tag, "_ack"}, int'(ack1), 1);
    chk({tag, "_cnt"}, int'(cnt1), exp_cnt);
    req1 = 1'b0;
    step();
    chk({tag, "_ackfall"}, int'(ack1), 0);
  endtask

  initial begin
    int n;
    rst0 = 1'b1; req0 = 1'b0; busy0 = 1'b0;
    rst1 = 1'b1; req1 = 1'b0; busy1 = 1'b0;
    ackseen = 1'b0;

    // 1: reset with init sequence
    step();
    step();
    chk("rst_outrst0", int'(out_rst0), 1);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_cnt0", int'(cnt0), 0);
    chk("rst_tmo0", int'(tmo0), 0);
    chk("rst_outrst1", int'(out_rst1), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    meas_high(0, n);
    chk("init_high", n, 3);
    for (int i = 0; i < 5; i++) begin
      if (ack0) ackseen = 1'b1;
      chk("init_low", int'(out_rst0), 0);
      step();
    end
    chk("init_noack", int'(ackseen), 0);
    chk("init_cnt", int'(cnt0), 0);

    // 2: normal request, REQ held
    req0 = 1'b1;
    step();
    meas_high(0, n);
    chk("req_high", n, 3);
    chk("rel_ack", int'(ack0), 0);
    step();
    chk("ackw_ack", int'(ack0), 1);
    chk("ackw_cnt", int'(cnt0), 1);
    step();
    chk("ackw_hold", int'(ack0), 1);
    req0 = 1'b0;
    step();
    chk("ack_fall", int'(ack0), 0);
    chk("idle_outrst", int'(out_rst0), 0);
    chk("req_tmo", int'(tmo0), 0);

    // 3: BUSY stuck -> timeout
    busy0 = 1'b1;
    req0 = 1'b1;
    step();
    meas_high(0, n);
    chk("tmo_high", n, 10);
    chk("tmo_flag", int'(tmo0), 1);
    step();
    chk("tmo_ack", int'(ack0), 1);
    chk("tmo_cnt", int'(cnt0), 2);
    req0 = 1'b0;
    busy0 = 1'b0;
    step();
    chk("tmo_sticky", int'(tmo0), 1);
    step();
    chk("tmo_sticky2", int'(tmo0), 1);

    // 4: single-cycle REQ pulse, 3 DRAIN cycles
    req0 = 1'b1;
    busy0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("pulse_tmoclr", int'(tmo0), 0);
    meas_high(5, n);
    chk("pulse_high", n, 5);
    step();
    chk("pulse_ack", int'(ack0), 1);
    chk("pulse_cnt", int'(cnt0), 3);
    step();
    chk("pulse_ack1cyc", int'(ack0), 0);
    chk("pulse_tmo", int'(tmo0), 0);

    // 6: saturating count on CNTW=2
    hs1(1, "sat1");
    hs1(2, "sat2");
    hs1(3, "sat3");
    hs1(3, "sat4");
    hs1(3, "sat5");

    // 5: RST during DRAIN, no init
    busy1 = 1'b1;
    req1 = 1'b1;
    step();
    step();
    step();
    step();
    chk("drain_outrst", int'(out_rst1), 1);
    rst1 = 1'b1;
    step();
    chk("mid_outrst", int'(out_rst1), 0);
    chk("mid_ack", int'(ack1), 0);
    chk("mid_cnt", int'(cnt1), 0);
    chk("mid_tmo", int'(tmo1), 0);
    rst1 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    chk("mid_idle", int'(out_rst1), 0);
    chk("mid_idle_ack", int'(ack1), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
